// File: rtl/multiplier_if.sv
// Handshake/operand bundle for the shift-and-add multiplier.
// The optional addend signal exists only when MULT_ADDEND_EN is defined.
interface multiplier_if #(
   parameter int M = 26,
   parameter int N = 14
);
   logic             start;
   logic [M-1:0]     multiplicand;
   logic [N-1:0]     multiplier;
`ifdef MULT_ADDEND_EN
   logic [N-1:0]     addend;
`endif
   logic             busy;
   logic             done;
   logic [M+N-1:0]   product;

`ifdef MULT_ADDEND_EN
   modport master (output start, multiplicand, multiplier, addend,
                   input  busy, done, product);
   modport slave  (input  start, multiplicand, multiplier, addend,
                   output busy, done, product);
`else
   modport master (output start, multiplicand, multiplier,
                   input  busy, done, product);
   modport slave  (input  start, multiplicand, multiplier,
                   output busy, done, product);
`endif
endinterface

// File: rtl/multiplier.sv
// Sequential shift-and-add unsigned multiplier, one multiplier bit per cycle.
// Fixed latency of N iterations; product register holds until the next result.
// Optional feature macro: MULT_ADDEND_EN -- accumulator starts at the addend,
// giving product = multiplicand * multiplier + addend.
module multiplier #(
   parameter int M = 26,
   parameter int N = 14
) (
   input  logic         clk,
   input  logic         rst_n,
   multiplier_if.slave  bus
);
   localparam int W  = M + N;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [W-1:0]    a_sh_q, a_sh_d;
   logic [N-1:0]    b_q, b_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [W-1:0]    product_q, product_d;
   logic [W-1:0]    acc_sum;
   logic            accept;
   logic            last_iter;

   assign accept    = (state_q == S_IDLE) && bus.start;
   assign last_iter = (count_q == CW'(N - 1));
   // Partial-product add; cannot overflow W bits even with a full addend.
   assign acc_sum   = acc_q + (b_q[0] ? a_sh_q : '0);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state: IDLE -> CALC (N cycles) -> DONE (1 cycle) -> IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = S_CALC;
         S_CALC:  if (last_iter) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: decoded straight from registered state, no input paths
   always_comb begin
      bus.busy    = (state_q != S_IDLE);
      bus.done    = (state_q == S_DONE);
      bus.product = product_q;
   end

   // Datapath next-state: load on accept, shift/accumulate during CALC
   always_comb begin
      count_d   = count_q;
      a_sh_d    = a_sh_q;
      b_d       = b_q;
      acc_d     = acc_q;
      product_d = product_q;
      if (accept) begin
         a_sh_d  = W'(bus.multiplicand);
         b_d     = bus.multiplier;
`ifdef MULT_ADDEND_EN
         acc_d   = W'(bus.addend);
`else
         acc_d   = '0;
`endif
         count_d = '0;
      end else if (state_q == S_CALC) begin
         acc_d   = acc_sum;
         a_sh_d  = a_sh_q << 1;
         b_d     = b_q >> 1;
         count_d = count_q + CW'(1);
         // Result register only moves on the edge entering DONE
         if (last_iter) product_d = acc_sum;
      end
   end

   // Datapath registers; reset discards any in-flight operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         a_sh_q    <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         product_q <= '0;
      end else begin
         count_q   <= count_d;
         a_sh_q    <= a_sh_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         product_q <= product_d;
      end
   end
endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for the shift-and-add multiplier (MULT_ADDEND_EN aware).
module tb_multiplier;
   localparam int M = 26;
   localparam int N = 14;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   multiplier_if #(.M(M), .N(N)) bus ();
   multiplier #(.M(M), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: plain arithmetic on the operands
   function automatic logic [63:0] ref_prod(input logic [M-1:0] a, input logic [N-1:0] b,
                                            input logic [N-1:0] ad);
      logic [63:0] r;
      r = 64'(a) * 64'(b);
`ifdef MULT_ADDEND_EN
      r = r + 64'(ad);
`endif
      return r;
   endfunction

   task automatic drive(input logic [M-1:0] a, input logic [N-1:0] b, input logic [N-1:0] ad);
      bus.multiplicand = a;
      bus.multiplier   = b;
`ifdef MULT_ADDEND_EN
      bus.addend       = ad;
`endif
   endtask

   task automatic scramble();
      drive(M'($urandom), N'($urandom), N'($urandom));
   endtask

   // One full operation with latency, hold and handshake checks
   task automatic run_op(input string tag, input logic [M-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] ad);
      logic [63:0] exp, prev;
      int lat, busy_cyc;
      logic held;
      exp  = ref_prod(a, b, ad);
      prev = 64'(bus.product);
      drive(a, b, ad);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      scramble();
      chk({tag, "_busy_accept"}, 64'(bus.busy), 64'd1);
      lat = 0; busy_cyc = 1; held = 1'b1;
      while (!bus.done && lat < 64) begin
         @(posedge clk); #1;
         lat++;
         if (bus.busy) busy_cyc++;
         if (!bus.done && 64'(bus.product) !== prev) held = 1'b0;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(N));
      chk({tag, "_hold"}, 64'(held), 64'd1);
      chk({tag, "_product"}, 64'(bus.product), exp);
      @(posedge clk); #1;
      chk({tag, "_done_low"}, 64'(bus.done), 64'd0);
      chk({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
      chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(N + 1));
      chk({tag, "_held_idle"}, 64'(bus.product), exp);
   endtask

   initial begin
      logic [63:0] exp;
      int n, dones;
      logic [M-1:0] ra;
      logic [N-1:0] rb, rd;

      bus.start = 1'b0;
      drive('0, '0, '0);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_product", 64'(bus.product), 64'd0);
      rst_n = 1'b1;

      // Directed products
      run_op("basic", M'(12345), N'(678), N'(0));
      chk("basic_value", 64'(bus.product), 64'd8369910);
      run_op("max", {M{1'b1}}, {N{1'b1}}, N'(0));
      chk("max_value", 64'(bus.product), 64'd1099444502529);
      run_op("a_zero", '0, N'(999), N'(0));
      run_op("b_zero", M'(777777), '0, N'(0));
`ifdef MULT_ADDEND_EN
      run_op("rt", M'(142857), N'(7), N'(1));
      chk("rt_value", 64'(bus.product), 64'd1000000);
      run_op("max_add", {M{1'b1}}, {N{1'b1}}, {N{1'b1}});
      chk("max_add_value", 64'(bus.product), 64'd1099444518912);
`endif

      // Random operands
      for (int i = 0; i < 20; i++) begin
         ra = M'($urandom); rb = N'($urandom); rd = N'($urandom);
         if (i % 5 == 0) rb = {N{1'b1}};
         run_op("rand", ra, rb, rd);
      end

      // Start pulsed during CALC is ignored and not queued
      exp = ref_prod(M'(1000), N'(3), N'(5));
      drive(M'(1000), N'(3), N'(5));
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      drive(M'(4242), N'(99), N'(1));
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      dones = 0;
      for (int c = 0; c < N + 8; c++) begin
         @(posedge clk); #1;
         if (bus.done) dones++;
      end
      chk("ign_done_count", 64'(dones), 64'd1);
      chk("ign_product", 64'(bus.product), exp);
      chk("ign_not_queued", 64'(bus.busy), 64'd0);

      // Start held high: results every N+2 cycles
      exp = ref_prod(M'(31337), N'(271), N'(9));
      drive(M'(31337), N'(271), N'(9));
      bus.start = 1'b1;
      n = 0;
      while (!bus.done && n < 64) begin @(posedge clk); #1; n++; end
      chk("b2b_first", 64'(n), 64'(N + 1));
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!bus.done && n < 64);
      chk("b2b_period", 64'(n), 64'(N + 2));
      chk("b2b_product", 64'(bus.product), exp);
      bus.start = 1'b0;
      n = 0;
      while (bus.busy && n < 64) begin @(posedge clk); #1; n++; end
      chk("b2b_idle", 64'(bus.busy), 64'd0);

      // Reset at iteration 7, asynchronous clear
      drive(M'(55555), N'(4321), N'(77));
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      chk("mid_pre_product_nz", 64'(bus.product != '0), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(bus.busy), 64'd0);
      chk("mid_rst_done", 64'(bus.done), 64'd0);
      chk("mid_rst_product", 64'(bus.product), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_op("post_rst", M'(12345), N'(678), N'(3));
      run_op("post_rst2", M'(9), N'(1), N'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
